// File: rtl/control_sequencer.sv
// control_sequencer: microstep sequencer with instruction register and
// retired-instruction counter. Two states: RUN advances the microstep and
// accepts IR loads; HALT freezes everything until reset.
//
// Optional feature: define SINGLE_STEP_EN to add single-step control.
// With it, i_step_mode=1 gates execution to one microstep per rising edge of
// i_step_req. Without it, the datapath is enabled whenever not halted.
//
// Ports:
//   i_clk          clock, all state on rising edge
//   i_reset        synchronous active-high reset
//   i_bus          shared data bus (IR load source)
//   i_instrregi    load IR from i_bus
//   i_adv          end current instruction (step back to 0)
//   i_halt         halt request
//   i_step_mode    single-step mode enable        (SINGLE_STEP_EN only)
//   i_step_req     single-step request, edge-used (SINGLE_STEP_EN only)
//   o_instruction  IR opcode field (upper bits)
//   o_operand      IR operand field (lower bits)
//   o_step         current microstep
//   o_halted       high while in HALT
//   o_cpu_en       datapath update enable for the current cycle (combinational)
//   o_instr_count  instructions retired since reset (wraps)
module control_sequencer #(
  parameter int unsigned INSTRUCTION_WIDTH = 4,
  parameter int unsigned INSTRUCTION_STEPS = 8,
  parameter int unsigned BUS_WIDTH         = 8,
  parameter int unsigned COUNT_WIDTH       = 16,
  localparam int unsigned STEP_WIDTH       = $clog2(INSTRUCTION_STEPS),
  localparam int unsigned OPERAND_WIDTH    = BUS_WIDTH - INSTRUCTION_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [BUS_WIDTH-1:0]         i_bus,
  input  logic                         i_instrregi,
  input  logic                         i_adv,
  input  logic                         i_halt,
`ifdef SINGLE_STEP_EN
  input  logic                         i_step_mode,
  input  logic                         i_step_req,
`endif
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [OPERAND_WIDTH-1:0]     o_operand,
  output logic [STEP_WIDTH-1:0]        o_step,
  output logic                         o_halted,
  output logic                         o_cpu_en,
  output logic [COUNT_WIDTH-1:0]       o_instr_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  state_t               state;
  logic [BUS_WIDTH-1:0] ir;

  // IR fields go straight to the decoder and bus driver
  assign o_instruction = ir[BUS_WIDTH-1 -: INSTRUCTION_WIDTH];
  assign o_operand     = ir[OPERAND_WIDTH-1:0];

`ifdef SINGLE_STEP_EN
  logic step_req_q;

  // Step-request history; runs every cycle so edges seen in any state count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      step_req_q <= 1'b0;
    end else begin
      step_req_q <= i_step_req;
    end
  end

  // In step mode only the cycle following a request rising edge is enabled
  assign o_cpu_en = (state == RUN) & (~i_step_mode | (i_step_req & ~step_req_q));
`else
  assign o_cpu_en = (state == RUN);
`endif

  // Sequencer state, microstep, IR and retired-instruction counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= RUN;
      o_halted      <= 1'b0;
      o_step        <= '0;
      ir            <= '0;
      o_instr_count <= '0;
    end else if ((state == RUN) && o_cpu_en) begin
      if (i_halt) begin
        // Halt beats adv and IR load in the same cycle
        state    <= HALT;
        o_halted <= 1'b1;
      end else begin
        if (i_instrregi) begin
          ir <= i_bus;
        end
        if (i_adv || (o_step == LAST_STEP)) begin
          o_step        <= '0;
          o_instr_count <= o_instr_count + COUNT_WIDTH'(1);
        end else begin
          o_step <= o_step + STEP_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: step sequencing, IR load, halt
// priority and stickiness, reset out of HALT, counter wrap (4-bit instance)
// and, when SINGLE_STEP_EN is defined, single-step gating.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] bus;
  logic       instrregi;
  logic       adv;
  logic       halt;
  logic [3:0] instruction;
  logic [3:0] operand;
  logic [2:0] step;
  logic       halted;
  logic       cpu_en;
  logic [15:0] instr_count;

  // Second instance with a 4-bit counter for wrap checking
  logic       reset4;
  logic [7:0] bus4;
  logic       instrregi4;
  logic       adv4;
  logic       halt4;
  logic [3:0] instruction4;
  logic [3:0] operand4;
  logic [2:0] step4;
  logic       halted4;
  logic       cpu_en4;
  logic [3:0] instr_count4;

`ifdef SINGLE_STEP_EN
  logic step_mode;
  logic step_req;
  logic step_mode4;
  logic step_req4;
`endif

  int checks;
  int errors;

  control_sequencer dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_bus         (bus),
    .i_instrregi   (instrregi),
    .i_adv         (adv),
    .i_halt        (halt),
`ifdef SINGLE_STEP_EN
    .i_step_mode   (step_mode),
    .i_step_req    (step_req),
`endif
    .o_instruction (instruction),
    .o_operand     (operand),
    .o_step        (step),
    .o_halted      (halted),
    .o_cpu_en      (cpu_en),
    .o_instr_count (instr_count)
  );

  control_sequencer #(.COUNT_WIDTH(4)) dut4 (
    .i_clk         (clk),
    .i_reset       (reset4),
    .i_bus         (bus4),
    .i_instrregi   (instrregi4),
    .i_adv         (adv4),
    .i_halt        (halt4),
`ifdef SINGLE_STEP_EN
    .i_step_mode   (step_mode4),
    .i_step_req    (step_req4),
`endif
    .o_instruction (instruction4),
    .o_operand     (operand4),
    .o_step        (step4),
    .o_halted      (halted4),
    .o_cpu_en      (cpu_en4),
    .o_instr_count (instr_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus        = 8'h00;
    instrregi  = 1'b0;
    adv        = 1'b0;
    halt       = 1'b0;
    reset4     = 1'b1;
    bus4       = 8'h00;
    instrregi4 = 1'b0;
    adv4       = 1'b0;
    halt4      = 1'b0;
`ifdef SINGLE_STEP_EN
    step_mode  = 1'b0;
    step_req   = 1'b0;
    step_mode4 = 1'b0;
    step_req4  = 1'b0;
`endif

    // Reset state
    tick();
    check("rst_step",   32'(step), 32'd0);
    check("rst_count",  32'(instr_count), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr",  32'(instruction), 32'd0);
    check("rst_oper",   32'(operand), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd1);
    reset = 1'b0;

    // Free-running sequence: 1..7, wrap to 0 (retire), 1, 2
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("seq_step_e%0d", e), 32'(step), 32'(e % 8));
      if (e == 7) check("seq_count_e7", 32'(instr_count), 32'd0);
      if (e == 8) check("seq_count_e8", 32'(instr_count), 32'd1);
    end

    // IR load at step 1, adv at step 5
    do_reset();
    tick();
    check("ld_step1", 32'(step), 32'd1);
    bus       = 8'h2C;
    instrregi = 1'b1;
    tick();
    instrregi = 1'b0;
    bus       = 8'h00;
    check("ld_instr", 32'(instruction), 32'h2);
    check("ld_oper",  32'(operand), 32'hC);
    check("ld_step2", 32'(step), 32'd2);
    tick();
    tick();
    tick();
    check("adv_pre_step", 32'(step), 32'd5);
    adv = 1'b1;
    tick();
    adv = 1'b0;
    check("adv_step",  32'(step), 32'd0);
    check("adv_count", 32'(instr_count), 32'd1);
    check("adv_instr", 32'(instruction), 32'h2);

    // Halt at step 2 beats adv and IR load; then sticky for 20 cycles
    tick();
    tick();
    check("hlt_pre_step", 32'(step), 32'd2);
    halt      = 1'b1;
    adv       = 1'b1;
    instrregi = 1'b1;
    bus       = 8'hFF;
    tick();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_step",   32'(step), 32'd2);
    check("hlt_instr",  32'(instruction), 32'h2);
    check("hlt_oper",   32'(operand), 32'hC);
    check("hlt_count",  32'(instr_count), 32'd1);
    check("hlt_cpu_en", 32'(cpu_en), 32'd0);
    halt = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    adv       = 1'b0;
    instrregi = 1'b0;
    bus       = 8'h00;
    check("sticky_halted", 32'(halted), 32'd1);
    check("sticky_step",   32'(step), 32'd2);
    check("sticky_instr",  32'(instruction), 32'h2);
    check("sticky_count",  32'(instr_count), 32'd1);
    check("sticky_cpu_en", 32'(cpu_en), 32'd0);

    // Reach count=5, step 3, halt, then reset out of HALT
    do_reset();
    adv = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    adv = 1'b0;
    tick();
    tick();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("h5_halted", 32'(halted), 32'd1);
    check("h5_step",   32'(step), 32'd3);
    check("h5_count",  32'(instr_count), 32'd5);
    reset = 1'b1;
    halt  = 1'b1;
    tick();
    reset = 1'b0;
    halt  = 1'b0;
    check("rh_halted", 32'(halted), 32'd0);
    check("rh_step",   32'(step), 32'd0);
    check("rh_instr",  32'(instruction), 32'd0);
    check("rh_oper",   32'(operand), 32'd0);
    check("rh_count",  32'(instr_count), 32'd0);
    tick();
    check("rh_run_step", 32'(step), 32'd1);

    // 4-bit counter wraps after 16 retirements
    reset4 = 1'b0;
    adv4   = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) check("wrap_count15", 32'(instr_count4), 32'd15);
    end
    adv4 = 1'b0;
    check("wrap_count0", 32'(instr_count4), 32'd0);
    check("wrap_step",   32'(step4), 32'd0);

`ifdef SINGLE_STEP_EN
    // Held request gives exactly one step; three pulses give three
    do_reset();
    step_mode = 1'b1;
    step_req  = 1'b0;
    #1;
    check("ss_idle_en", 32'(cpu_en), 32'd0);
    tick();
    check("ss_idle_step", 32'(step), 32'd0);
    step_req = 1'b1;
    #1;
    check("ss_edge_en", 32'(cpu_en), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("ss_hold_step", 32'(step), 32'd1);
    check("ss_hold_en",   32'(cpu_en), 32'd0);
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b0;
      tick();
      step_req = 1'b1;
      tick();
    end
    step_req = 1'b0;
    check("ss_pulse_step", 32'(step), 32'd4);
    step_mode = 1'b0;
    tick();
    check("ss_free_step", 32'(step), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
